// File: rtl/axis_nch_join_wrapper_pkg.sv
// ty_axis_pkg: run-state type and FIFO sizing helpers shared by the join wrapper
package ty_axis_pkg;
   localparam int C_MAX_CHANNELS = 8;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   function automatic int ptr_w(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction
   function automatic int occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/axis_nch_join_wrapper_if.sv
// axis_nch_join_wrapper_if: bundle of run control, AXI-stream and kernel handshake signals
//   slave  : wrapper side, drives busy/done, s_tready, m_*, k_ivalid/k_idata, k_oready
//   master : environment side, drives cfg_*, s_tvalid/s_tdata, m_tready, k_iready, k_ovalid/k_odata
interface axis_nch_join_wrapper_if
   import ty_axis_pkg::*;
   #(
      parameter int C_DATA_WIDTH   = 512,
      parameter int C_NUM_CHANNELS = 2,
      parameter int C_LEN_WIDTH    = 32
   );
   logic                                          cfg_start;
   logic [C_LEN_WIDTH-1:0]                        cfg_len;
   logic                                          busy;
   logic                                          done;
   logic [C_NUM_CHANNELS-1:0]                     s_tvalid;
   logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]   s_tdata;
   logic [C_NUM_CHANNELS-1:0]                     s_tready;
   logic                                          m_tvalid;
   logic [C_DATA_WIDTH-1:0]                       m_tdata;
   logic                                          m_tlast;
   logic                                          m_tready;
   logic                                          k_ivalid;
   logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]   k_idata;
   logic                                          k_iready;
   logic                                          k_ovalid;
   logic [C_DATA_WIDTH-1:0]                       k_odata;
   logic                                          k_oready;
   modport slave (
      input  cfg_start, cfg_len, s_tvalid, s_tdata, m_tready, k_iready, k_ovalid, k_odata,
      output busy, done, s_tready, m_tvalid, m_tdata, m_tlast, k_ivalid, k_idata, k_oready
   );
   modport master (
      output cfg_start, cfg_len, s_tvalid, s_tdata, m_tready, k_iready, k_ovalid, k_odata,
      input  busy, done, s_tready, m_tvalid, m_tdata, m_tlast, k_ivalid, k_idata, k_oready
   );
endinterface

// File: rtl/axis_nch_join_wrapper_fifo.sv
// ty_sync_fifo: single-clock FIFO with registered write and occupancy-counter full/empty
//   clk, rst : clock and synchronous active-high flush
//   push/din : write request and data, ignored when full unless a pop frees the slot
//   pop/dout : read request and head data, ignored when empty
//   full, empty, count : decoded from the registered occupancy only (no pop-through)
module ty_sync_fifo
   import ty_axis_pkg::*;
   #(
      parameter int W = 8,
      parameter int D = 4
   ) (
      input  logic                  clk,
      input  logic                  rst,
      input  logic                  push,
      input  logic                  pop,
      input  logic [W-1:0]          din,
      output logic [W-1:0]          dout,
      output logic                  full,
      output logic                  empty,
      output logic [occ_w(D)-1:0]   count
   );
   localparam int PW = ptr_w(D);
   localparam int OW = occ_w(D);
   logic [W-1:0]  mem_q [D];
   logic [PW-1:0] wr_q, rd_q;
   logic [OW-1:0] cnt_q;
   logic          do_push, do_pop;
   assign full    = cnt_q == OW'(D);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign dout    = mem_q[rd_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + OW'(do_push) - OW'(do_pop);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/axis_nch_join_wrapper.sv
// axis_nch_join_wrapper: joins N buffered AXI-stream inputs into one kernel beat and streams kernel results out with length-controlled tlast/done
//   aclk, areset : clock and synchronous active-high reset (aborts any run without done)
//   bus (slave)  : cfg_start/cfg_len/busy/done run control, s_* per-channel inputs,
//                  k_* kernel handshake, m_* output stream
module axis_nch_join_wrapper
   import ty_axis_pkg::*;
   #(
      parameter int C_DATA_WIDTH   = 512,
      parameter int C_NUM_CHANNELS = 2,
      parameter int C_IN_DEPTH     = 4,
      parameter int C_OUT_DEPTH    = 4,
      parameter int C_LEN_WIDTH    = 32
   ) (
      input logic                    aclk,
      input logic                    areset,
      axis_nch_join_wrapper_if.slave bus
   );
   localparam int N  = C_NUM_CHANNELS;
   localparam int DW = C_DATA_WIDTH;
   localparam int LW = C_LEN_WIDTH;
   localparam int IW = occ_w(C_IN_DEPTH);
   localparam int OW = occ_w(C_OUT_DEPTH);
   state_e                 state_q;
   logic [LW-1:0]          len_q, in_cnt_q, out_cnt_q;
   logic                   busy_q, done_q;
   logic [N-1:0]           in_full, in_empty, s_rdy;
   logic [N-1:0][IW-1:0]   in_occ;
   logic [N-1:0][DW-1:0]   in_dout;
   logic                   run, join_hs, out_push, out_pop, out_full, out_empty, at_last, last_hs;
   logic [OW-1:0]          out_occ_unused;
   assign run = state_q == RUN;
   // A channel stops accepting once what it has delivered plus what it holds covers the run length.
   always_comb begin
      s_rdy = '0;
      for (int i = 0; i < N; i++)
         s_rdy[i] = run & ~in_full[i] & (({1'b0, in_cnt_q} + (LW+1)'(in_occ[i])) < {1'b0, len_q});
   end
   for (genvar g = 0; g < N; g++) begin : g_in
      ty_sync_fifo #(.W(DW), .D(C_IN_DEPTH)) u_in_fifo (
         .clk   (aclk),
         .rst   (areset),
         .push  (bus.s_tvalid[g] & s_rdy[g]),
         .pop   (join_hs),
         .din   (bus.s_tdata[g]),
         .dout  (in_dout[g]),
         .full  (in_full[g]),
         .empty (in_empty[g]),
         .count (in_occ[g])
      );
   end
   assign bus.s_tready = s_rdy;
   assign bus.k_ivalid = run & (&(~in_empty));
   assign bus.k_idata  = in_dout;
   assign join_hs      = bus.k_ivalid & bus.k_iready;
   assign bus.k_oready = (state_q != IDLE) & ~out_full;
   assign out_push     = bus.k_ovalid & bus.k_oready;
   assign out_pop      = bus.m_tvalid & bus.m_tready;
   ty_sync_fifo #(.W(DW), .D(C_OUT_DEPTH)) u_out_fifo (
      .clk   (aclk),
      .rst   (areset),
      .push  (out_push),
      .pop   (out_pop),
      .din   (bus.k_odata),
      .dout  (bus.m_tdata),
      .full  (out_full),
      .empty (out_empty),
      .count (out_occ_unused)
   );
   assign bus.m_tvalid = ~out_empty;
   assign at_last      = out_cnt_q == len_q - LW'(1);
   assign bus.m_tlast  = bus.m_tvalid & at_last;
   assign last_hs      = out_pop & at_last;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (join_hs) in_cnt_q <= in_cnt_q + LW'(1);
         if (out_pop) out_cnt_q <= out_cnt_q + LW'(1);
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.cfg_start) begin
               len_q     <= bus.cfg_len;
               in_cnt_q  <= '0;
               out_cnt_q <= '0;
               state_q   <= bus.cfg_len == '0 ? DONE : RUN;
               busy_q    <= bus.cfg_len != '0;
               done_q    <= bus.cfg_len == '0;
            end
            RUN, DRAIN: if (last_hs) begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else if (join_hs && in_cnt_q + LW'(1) == len_q) state_q <= DRAIN;
            DONE: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_nch_join_wrapper.sv
// tb_axis_nch_join_wrapper: randomized and directed runs checked against a queue-based source/kernel/sink model
module tb_axis_nch_join_wrapper;
   localparam int DW = 32;
   localparam int N  = 2;
   localparam int ID = 4;
   localparam int OD = 4;
   localparam int LW = 32;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   axis_nch_join_wrapper_if #(.C_DATA_WIDTH(DW), .C_NUM_CHANNELS(N), .C_LEN_WIDTH(LW)) bus();
   axis_nch_join_wrapper #(
      .C_DATA_WIDTH(DW), .C_NUM_CHANNELS(N), .C_IN_DEPTH(ID), .C_OUT_DEPTH(OD), .C_LEN_WIDTH(LW)
   ) dut (
      .aclk   (clk),
      .areset (rst),
      .bus    (bus)
   );
   int n_chk = 0, n_err = 0, cyc = 0;
   int k_len, off_n, hold_ki, hold_mo, t_start;
   bit rnd, active, mv_seen;
   int dly [N], acc_n [N], first_push [N];
   logic [DW-1:0] src_d [N][64];
   logic [DW-1:0] kq [$];
   int n_join, n_kout, n_mout, n_done, first_kv, first_join, last_m, done_cyc, acc_hold, nko_hold;
   logic busy_s, kor_hold;
   logic [N-1:0] rdy_hold, rdy_join, rdy_post;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic logic [DW-1:0] kfun(input int j);
      logic [DW-1:0] a;
      a = 32'h1234_5678;
      for (int i = 0; i < N; i++) a = (a * DW'(3)) ^ src_d[i][j];
      return a;
   endfunction
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.s_tvalid[i] = active && acc_n[i] < off_n && cyc - t_start > dly[i] && (!rnd || $urandom_range(3) != 0);
         bus.s_tdata[i]  = src_d[i][acc_n[i] & 63];
      end
      bus.k_iready  = cyc - t_start > hold_ki && (!rnd || $urandom_range(3) != 0);
      bus.k_ovalid  = kq.size() > 0 && (!rnd || $urandom_range(3) != 0);
      bus.k_odata   = kq.size() > 0 ? kq[0] : '0;
      bus.m_tready  = cyc - t_start > hold_mo && (!rnd || $urandom_range(3) != 0);
      bus.cfg_start = 1'b0;
   endtask
   task automatic monitor();
      logic [N-1:0] allow;
      if (hold_ki > 0 && cyc == t_start + hold_ki) begin
         rdy_hold = bus.s_tready;
         acc_hold = acc_n[0];
      end
      if (hold_mo > 0 && cyc == t_start + hold_mo) begin
         kor_hold = bus.k_oready;
         nko_hold = n_kout;
      end
      if (cyc == t_start + 1) busy_s = bus.busy;
      if (n_join > 0 && cyc == first_join + 1) rdy_post = bus.s_tready;
      if (active && bus.m_tvalid) mv_seen = 1'b1;
      for (int i = 0; i < N; i++) allow[i] = active && cyc > t_start && acc_n[i] < k_len;
      chk("s_tready_cap", 64'(bus.s_tready & ~allow), 0);
      for (int i = 0; i < N; i++)
         if (bus.s_tvalid[i] && bus.s_tready[i]) begin
            if (first_push[i] < 0) first_push[i] = cyc;
            acc_n[i]++;
         end
      if (bus.k_ivalid && first_kv < 0) first_kv = cyc;
      if (bus.k_ivalid && bus.k_iready) begin
         if (n_join == 0) begin
            first_join = cyc;
            rdy_join   = bus.s_tready;
         end
         for (int i = 0; i < N; i++) chk("k_idata", 64'(bus.k_idata[i]), 64'(src_d[i][n_join & 63]));
         kq.push_back(kfun(n_join & 63));
         n_join++;
      end
      if (bus.k_ovalid && bus.k_oready) begin
         void'(kq.pop_front());
         n_kout++;
      end
      if (bus.m_tvalid && bus.m_tready) begin
         chk("m_tdata", 64'(bus.m_tdata), 64'(kfun(n_mout & 63)));
         chk("m_tlast", 64'(bus.m_tlast), 64'(n_mout == k_len - 1));
         n_mout++;
         last_m = cyc;
      end
      if (bus.done) begin
         n_done++;
         done_cyc = cyc;
         active   = 1'b0;
      end
   endtask
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      drive();
   endtask
   task automatic start(input int len, offer, d1, kih, moh, input bit r);
      k_len = len; off_n = offer; hold_ki = kih; hold_mo = moh; rnd = r;
      for (int i = 0; i < N; i++) begin
         dly[i] = i == 0 ? 0 : d1;
         acc_n[i] = 0;
         first_push[i] = -1;
         for (int j = 0; j < 64; j++) src_d[i][j] = $urandom;
      end
      n_join = 0; n_kout = 0; n_mout = 0; n_done = 0;
      first_kv = -1; first_join = -1; last_m = -1; done_cyc = -1;
      mv_seen = 1'b0; busy_s = 1'b0; acc_hold = 0; nko_hold = 0; kor_hold = 1'b0;
      rdy_hold = '0; rdy_join = '0; rdy_post = '0;
      kq.delete();
      bus.cfg_len   = LW'(len);
      bus.cfg_start = 1'b1;
      t_start = cyc;
      active  = 1'b1;
   endtask
   task automatic run(input int len, offer, d1, kih, moh, input bit r);
      int b;
      start(len, offer, d1, kih, moh, r);
      b = 0;
      while (n_done == 0 && b < 3000) begin
         step();
         b++;
      end
      repeat (4) step();
      chk("done_once", n_done, 1);
      for (int i = 0; i < N; i++) chk("accepted", acc_n[i], offer < len ? offer : len);
      chk("k_beats", n_join, len);
      chk("k_outs", n_kout, len);
      chk("m_beats", n_mout, len);
      chk("done_lat", done_cyc - (len > 0 ? last_m : t_start), 1);
      chk("busy_run", 64'(busy_s), 64'(len != 0));
      chk("busy_end", 64'(bus.busy), 0);
   endtask
   task automatic chk_reset_outputs();
      chk("rst_s_tready", 64'(bus.s_tready), 0);
      chk("rst_k_ivalid", 64'(bus.k_ivalid), 0);
      chk("rst_k_oready", 64'(bus.k_oready), 0);
      chk("rst_m_tvalid", 64'(bus.m_tvalid), 0);
      chk("rst_m_tlast", 64'(bus.m_tlast), 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_done", 64'(bus.done), 0);
   endtask
   initial begin
      rst = 1'b1;
      active = 1'b0; rnd = 1'b0; k_len = 0; off_n = 0; hold_ki = 0; hold_mo = 0; t_start = -10;
      n_join = 0; n_kout = 0; n_mout = 0; n_done = 0; first_join = -1;
      for (int i = 0; i < N; i++) begin
         acc_n[i] = 0; dly[i] = 0; first_push[i] = -1;
      end
      bus.cfg_start = 1'b0; bus.cfg_len = '0;
      bus.s_tvalid = '0; bus.s_tdata = '0; bus.m_tready = 1'b0;
      bus.k_iready = 1'b0; bus.k_ovalid = 1'b0; bus.k_odata = '0;
      repeat (3) step();
      chk_reset_outputs();
      rst = 1'b0;
      step();
      run(4, 4, 3, 0, 0, 1'b0);
      chk("skew_ch1_start", first_push[1] - first_push[0], 3);
      chk("skew_kvalid", first_kv - first_push[0], 4);
      run(20, 20, 0, 12, 0, 1'b0);
      chk("bp_acc", acc_hold, ID);
      chk("bp_rdy_hold", 64'(rdy_hold), 0);
      chk("bp_rdy_join", 64'(rdy_join), 0);
      chk("bp_rdy_post", 64'(rdy_post), 64'({N{1'b1}}));
      run(10, 10, 0, 0, 12, 1'b0);
      chk("os_k_oready", 64'(kor_hold), 0);
      chk("os_kouts", nko_hold, OD);
      run(0, 3, 0, 0, 0, 1'b0);
      chk("zl_m_tvalid", 64'(mv_seen), 0);
      run(3, 6, 0, 0, 0, 1'b0);
      start(8, 2, 0, 1000, 0, 1'b0);
      repeat (4) step();
      chk("mid_acc", acc_n[0] + acc_n[1], 4);
      chk("mid_busy", 64'(bus.busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      active = 1'b0;
      kq.delete();
      chk_reset_outputs();
      n_done = 0;
      repeat (5) step();
      chk("rst_no_done", n_done, 0);
      run(2, 2, 0, 0, 0, 1'b0);
      for (int r = 0; r < 8; r++) begin
         int len;
         len = $urandom_range(12, 1);
         run(len, len + $urandom_range(3, 0), $urandom_range(5, 0), $urandom_range(6, 0), $urandom_range(6, 0), 1'b1);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/axis_nch_join_wrapper.md
Name: axis_nch_join_wrapper

Overview:
Parametrised successor to the SDx-to-TyBEC top wrapper. Bridges N independent AXI-stream input channels and one AXI-stream output to the single-handshake TyBEC kernel interface (ivalid/iready/ovalid/oready). Each input channel has its own FIFO, so channels may arrive skewed. A joiner presents a kernel beat only when every channel has data. A length-controlled run FSM counts beats and generates m_tlast and done.

Parameters:
C_DATA_WIDTH, 512, width of one packed vector beat per channel (32*TY_GVECT).
C_NUM_CHANNELS, 2, number of input channels; legal range 1..8.
C_IN_DEPTH, 4, per-input FIFO depth; power of 2, at least 2.
C_OUT_DEPTH, 4, output FIFO depth; power of 2, at least 2.
C_LEN_WIDTH, 32, width of the beat-count register.

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse that starts a run; sampled only in IDLE
cfg_len  in  C_LEN_WIDTH  beats per run; latched on cfg_start
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of run
s_tvalid  in  C_NUM_CHANNELS  per-channel input valid
s_tdata  in  [C_NUM_CHANNELS][C_DATA_WIDTH]  per-channel input data
s_tready  out  C_NUM_CHANNELS  per-channel input ready
m_tvalid  out  1  output valid
m_tdata  out  C_DATA_WIDTH  output data
m_tlast  out  1  marks the final beat of a run
m_tready  in  1  output sink ready
k_ivalid  out  1  joined beat valid to kernel
k_idata  out  [C_NUM_CHANNELS][C_DATA_WIDTH]  joined data to kernel; index i = channel i
k_iready  in  1  kernel back-pressure
k_ovalid  in  1  kernel output valid
k_odata  in  C_DATA_WIDTH  kernel output data
k_oready  out  1  ready to kernel output

Behaviour:
- Reset. All FIFOs flush; counters clear; FSM goes to IDLE. Outputs: s_tready=0, k_ivalid=0, k_oready=0, m_tvalid=0, m_tlast=0, busy=0, done=0. An areset during RUN or DRAIN aborts the run and raises no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE + cfg_start with cfg_len != 0 -> RUN. Latch len. Clear in_cnt and out_cnt.
  - IDLE + cfg_start with cfg_len == 0 -> DONE. No beats are moved.
  - RUN -> DRAIN when in_cnt reaches len.
  - RUN or DRAIN -> DONE on the output handshake where out_cnt == len-1.
  - DONE -> IDLE after 1 cycle. done=1 only in DONE.
  - cfg_start outside IDLE is ignored.
- Input side.
  - s_tready[i] = (state==RUN) & !in_full[i] & (in_cnt + occupancy_i < len). A channel can never buffer beyond len.
  - A push happens on s_tvalid[i] & s_tready[i]. Channels are fully independent.
- Join.
  - k_ivalid = (state==RUN) & all input FIFOs non-empty.
  - On k_ivalid & k_iready, every input FIFO pops in the same cycle and in_cnt increments.
  - k_idata is the concatenation of the FIFO heads.
- Latency.
  - FIFO writes are registered: a beat pushed in cycle t is visible at the head in cycle t+1. Minimum s-to-k latency is 1 cycle.
  - k-to-m latency is likewise 1 cycle.
- Output side.
  - k_oready = (state != IDLE) & !out_full.
  - A push happens on k_ovalid & k_oready.
  - m_tvalid = out FIFO non-empty.
  - m_tlast = m_tvalid & (out_cnt == len-1).
  - out_cnt increments on m_tvalid & m_tready.
- FIFO rules.
  - Push and pop in the same cycle leave the count unchanged; this is legal when full, and the pop frees space.
  - Ready signals are driven from the registered full flag only, with no pop-through.
  - Pointers wrap modulo depth. Full and empty are distinguished by an occupancy counter of width clog2(depth)+1.
- Counters are C_LEN_WIDTH bits unsigned. len == 2^C_LEN_WIDTH - 1 is legal. No wrap within a run.
- Kernel outputs arriving in IDLE are dropped by design (k_oready=0). The kernel must have been drained before the next cfg_start.

Decomposition:
- Package ty_axis_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - localparam functions for pointer width (clog2) and occupancy width;
  - C_MAX_CHANNELS = 8.
- Sub-module ty_sync_fifo, parametrised by width and depth, with push, pop, din, dout, full, empty and count ports.
  - Instantiated C_NUM_CHANNELS times on the input side (generate loop) and once on the output side.

Test Plan:
- Skewed arrival. N=2, len=4; ch0 sends 4 beats back-to-back from t0; ch1 sends from t0+3. Required: k_ivalid first high at t0+4; k_idata pairs stay in order; exactly 4 kernel handshakes; m_tlast on the 4th output; done pulses once.
- Back-pressure. Hold k_iready=0 while feeding C_IN_DEPTH=4 beats per channel. Required: s_tready drops after 4 beats and returns 1 cycle after k_iready=1 and the first pop.
- Output stall. Hold m_tready=0 with a kernel producing 1 beat/cycle. Required: k_oready=0 after 4 buffered beats; no data loss or duplication after release.
- Zero length. cfg_start with cfg_len=0. Required: done=1 on the next cycle; s_tready stays 0 throughout; m_tvalid never asserts.
- Length cap. len=3, source offers 6 beats per channel. Required: only 3 are accepted per channel; s_tready=0 afterwards; m_tlast on beat 3.
- Reset mid-run. Assert areset in RUN with 2 beats buffered. Required: all outputs at reset values next cycle; no done pulse; a fresh run with len=2 completes correctly.
